// File: rtl/cpu_isa_pkg.sv
// cpu_isa_pkg: shared 16-bit ISA opcodes and instruction field positions.
package cpu_isa_pkg;
    localparam int OPW = 4;
    localparam logic [OPW-1:0] OP_RTYPE   = 4'h0;
    localparam logic [OPW-1:0] OP_ANDI    = 4'h1;
    localparam logic [OPW-1:0] OP_ORI     = 4'h2;
    localparam logic [OPW-1:0] OP_XORI    = 4'h3;
    localparam logic [OPW-1:0] OP_SPECIAL = 4'h4;
    localparam logic [OPW-1:0] OP_ADDI    = 4'h5;
    localparam logic [OPW-1:0] OP_SHIFT   = 4'h8;
    localparam logic [OPW-1:0] OP_SUBI    = 4'h9;
    localparam logic [OPW-1:0] OP_CMPI    = 4'hB;
    localparam logic [OPW-1:0] OP_BCOND   = 4'hC;
    localparam logic [OPW-1:0] OP_MOVI    = 4'hD;
    localparam logic [OPW-1:0] OP_LUI     = 4'hF;
    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 8;
    localparam int EXT_HI = 7;
    localparam int EXT_LO = 4;
    localparam int RS_HI  = 3;
    localparam int RS_LO  = 0;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;
endpackage

// File: rtl/imm_classify.sv
// imm_classify: maps an opcode to {is_imm, imm_signed}; shared with the control unit.
module imm_classify
    import cpu_isa_pkg::*;
(
    input  logic [OPW-1:0] opcode,
    output logic           is_imm,
    output logic           imm_signed
);
    assign imm_signed = opcode inside {OP_ADDI, OP_SUBI, OP_CMPI, OP_BCOND};
    assign is_imm = imm_signed || (opcode inside {OP_ANDI, OP_ORI, OP_XORI, OP_MOVI, OP_LUI});
endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: buffered instruction decode feeding the sign extender and register file.
// IMM_DECODE_SKID_EN selects a 2-entry buffer with ready driven from state only.
module imm_decode_stage
    import cpu_isa_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic [15:0]    instr,
    input  logic           instr_valid,
    output logic           instr_ready,
    input  logic           out_ready,
    output logic           out_valid,
    output logic [OPW-1:0] opcode,
    output logic [3:0]     rdest,
    output logic [3:0]     ext,
    output logic [3:0]     rsrc,
    output logic [7:0]     imm8,
    output logic           imm_signed,
    output logic           is_imm
);
    localparam logic [1:0] EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2;
    logic [1:0]  state;
    logic [15:0] head, h;
    logic        xfer_in, xfer_out, cls_imm, cls_signed;
    assign out_valid = state != EMPTY;
    assign xfer_in   = instr_valid && instr_ready;
    assign xfer_out  = out_valid && out_ready;
`ifdef IMM_DECODE_SKID_EN
    logic [15:0] tail;
    assign instr_ready = state != TWO;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
            head  <= '0;
            tail  <= '0;
        end else if (state == TWO) begin
            if (xfer_out) begin
                head  <= tail;
                state <= ONE;
            end
        end else if (xfer_in && (state == EMPTY || xfer_out)) begin
            head  <= instr;
            state <= ONE;
        end else if (xfer_in) begin
            tail  <= instr;
            state <= TWO;
        end else if (xfer_out) begin
            state <= EMPTY;
        end
    end
`else
    assign instr_ready = !out_valid || out_ready;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
            head  <= '0;
        end else if (xfer_in) begin
            head  <= instr;
            state <= ONE;
        end else if (xfer_out) begin
            state <= EMPTY;
        end
    end
`endif
    // Gate the head so every decoded output reads 0 while nothing is valid.
    assign h     = out_valid ? head : '0;
    assign opcode = h[OPC_HI:OPC_LO];
    assign rdest  = h[RD_HI:RD_LO];
    assign ext    = h[EXT_HI:EXT_LO];
    assign rsrc   = h[RS_HI:RS_LO];
    assign imm8   = h[IMM_HI:IMM_LO];
    imm_classify u_cls (.opcode(opcode), .is_imm(cls_imm), .imm_signed(cls_signed));
    assign is_imm     = out_valid && cls_imm;
    assign imm_signed = out_valid && cls_signed;
endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage: table vectors plus scoreboard for imm_decode_stage (either IMM_DECODE_SKID_EN build).
module tb_imm_decode_stage;
    logic        clk = 0, reset = 0, instr_valid = 0, out_ready = 0;
    logic [15:0] instr = 0;
    logic        instr_ready, out_valid, imm_signed, is_imm;
    logic [3:0]  opcode, rdest, ext, rsrc;
    logic [7:0]  imm8;
    int checks = 0, passes = 0;
    logic [15:0] sb[$];
    logic [15:0] imm_mask = 16'hBA2E, sgn_mask = 16'h1A20;

    typedef struct {
        logic [15:0] w;
        logic [3:0]  opc, rd, ex, rs;
        logic [7:0]  imm;
        logic        isi, sg;
        logic [15:0] sext;
    } vec_t;
    vec_t vecs[16];

    imm_decode_stage dut (.clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .out_ready(out_ready), .out_valid(out_valid), .opcode(opcode),
        .rdest(rdest), .ext(ext), .rsrc(rsrc), .imm8(imm8), .imm_signed(imm_signed), .is_imm(is_imm));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [25:0] fields();
        return {opcode, rdest, ext, rsrc, imm8, is_imm, imm_signed};
    endfunction

    function automatic logic [15:0] sext_of();
        return imm_signed ? {{8{imm8[7]}}, imm8} : {8'h00, imm8};
    endfunction

    // Scoreboard: pop on transfer out, then push on transfer in.
    always @(negedge clk) begin
        if (reset) sb.delete();
        else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("sb_unexpected_out", {6'h0, fields()}, 32'hFFFFFFFF);
                else begin
                    logic [15:0] e;
                    e = sb.pop_front();
                    chk("sb_word", {6'h0, fields()},
                        {6'h0, e, e[7:0], imm_mask[e[15:12]], sgn_mask[e[15:12]]});
                end
            end
            if (instr_valid && instr_ready) sb.push_back(instr);
        end
    end

    task automatic send(input logic [15:0] w);
        int n = 0;
        instr = w;
        instr_valid = 1;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_ready && n < 50);
        if (!instr_ready) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk) #1;
        instr_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1;
        do begin
            @(negedge clk);
            n++;
        end while (out_valid && n < 20);
        chk("drain_empty", {31'h0, out_valid}, 32'd0);
        chk("drain_zero", {6'h0, fields()}, 32'd0);
        chk("drain_sb", sb.size(), 32'd0);
        @(posedge clk) #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{16'h51FF, 4'h5, 4'h1, 4'hF, 4'hF, 8'hFF, 1'b1, 1'b1, 16'hFFFF};
        vecs[1]  = '{16'h120F, 4'h1, 4'h2, 4'h0, 4'hF, 8'h0F, 1'b1, 1'b0, 16'h000F};
        vecs[2]  = '{16'h9A80, 4'h9, 4'hA, 4'h8, 4'h0, 8'h80, 1'b1, 1'b1, 16'hFF80};
        vecs[3]  = '{16'hB37F, 4'hB, 4'h3, 4'h7, 4'hF, 8'h7F, 1'b1, 1'b1, 16'h007F};
        vecs[4]  = '{16'hC6F0, 4'hC, 4'h6, 4'hF, 4'h0, 8'hF0, 1'b1, 1'b1, 16'hFFF0};
        vecs[5]  = '{16'hD4AB, 4'hD, 4'h4, 4'hA, 4'hB, 8'hAB, 1'b1, 1'b0, 16'h00AB};
        vecs[6]  = '{16'hF9C3, 4'hF, 4'h9, 4'hC, 4'h3, 8'hC3, 1'b1, 1'b0, 16'h00C3};
        vecs[7]  = '{16'h2155, 4'h2, 4'h1, 4'h5, 4'h5, 8'h55, 1'b1, 1'b0, 16'h0055};
        vecs[8]  = '{16'h3EEE, 4'h3, 4'hE, 4'hE, 4'hE, 8'hEE, 1'b1, 1'b0, 16'h00EE};
        vecs[9]  = '{16'h0123, 4'h0, 4'h1, 4'h2, 4'h3, 8'h23, 1'b0, 1'b0, 16'h0023};
        vecs[10] = '{16'h4FFF, 4'h4, 4'hF, 4'hF, 4'hF, 8'hFF, 1'b0, 1'b0, 16'h00FF};
        vecs[11] = '{16'h8765, 4'h8, 4'h7, 4'h6, 4'h5, 8'h65, 1'b0, 1'b0, 16'h0065};
        vecs[12] = '{16'h6ABC, 4'h6, 4'hA, 4'hB, 4'hC, 8'hBC, 1'b0, 1'b0, 16'h00BC};
        vecs[13] = '{16'h7F81, 4'h7, 4'hF, 4'h8, 4'h1, 8'h81, 1'b0, 1'b0, 16'h0081};
        vecs[14] = '{16'hA999, 4'hA, 4'h9, 4'h9, 4'h9, 8'h99, 1'b0, 1'b0, 16'h0099};
        vecs[15] = '{16'hE0F0, 4'hE, 4'h0, 4'hF, 4'h0, 8'hF0, 1'b0, 1'b0, 16'h00F0};

        // reset with a valid word presented
        @(posedge clk) #1;
        reset = 1; instr = 16'h51FF; instr_valid = 1;
        @(posedge clk) #1;
        reset = 0; instr_valid = 0;
        chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_instr_ready", {31'h0, instr_ready}, 32'd1);
        chk("rst_imm8", {24'h0, imm8}, 32'd0);

        // one word per vector, checked the cycle after acceptance
        for (int i = 0; i < 16; i++) begin
            out_ready = 1;
            instr = vecs[i].w; instr_valid = 1;
            @(posedge clk) #1;
            instr_valid = 0;
            chk($sformatf("vec%0d_valid", i), {31'h0, out_valid}, 32'd1);
            chk($sformatf("vec%0d_fields", i), {6'h0, fields()},
                {6'h0, vecs[i].opc, vecs[i].rd, vecs[i].ex, vecs[i].rs, vecs[i].imm, vecs[i].isi, vecs[i].sg});
            chk($sformatf("vec%0d_sext", i), {16'h0, sext_of()}, {16'h0, vecs[i].sext});
            @(posedge clk) #1;
        end
        drain();

        // backpressure: head must hold while the next word waits
        out_ready = 0;
        send(16'h5301);
`ifdef IMM_DECODE_SKID_EN
        send(16'h9402);
        instr = 16'hD503;
`else
        instr = 16'h9402;
`endif
        instr_valid = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("bp_ready_low", {31'h0, instr_ready}, 32'd0);
        chk("bp_head_hold", {16'h0, opcode, rdest, imm8}, 32'h5301);
        chk("bp_valid", {31'h0, out_valid}, 32'd1);
        @(posedge clk) #1;
        out_ready = 1;
`ifndef IMM_DECODE_SKID_EN
        send(16'h9402);
`endif
        send(16'hD503);
        drain();

        // streaming: one word per cycle, visible the cycle after acceptance
        out_ready = 1;
        for (int i = 0; i < 100; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            instr = w; instr_valid = 1;
            @(posedge clk) #1;
            chk("stream_latency", {13'h0, out_valid, instr_ready, 1'b0, opcode, rdest, ext, rsrc},
                {13'h0, 1'b1, 1'b1, 1'b0, w});
        end
        instr_valid = 0;
        drain();

        // ONE with simultaneous in and out: head replaced, nothing lost
        out_ready = 0;
        send(16'h1234);
        out_ready = 1; instr = 16'hD777; instr_valid = 1;
        @(posedge clk) #1;
        instr_valid = 0; out_ready = 0;
        chk("simul_head", {15'h0, out_valid, opcode, rdest, ext, rsrc}, {15'h0, 1'b1, 16'hD777});
        drain();

        // reset while full discards everything and ignores the same-cycle handshake
        out_ready = 0;
        send(16'h5AAA);
`ifdef IMM_DECODE_SKID_EN
        send(16'h9BBB);
`endif
        reset = 1; instr = 16'hFCCC; instr_valid = 1; out_ready = 1;
        @(posedge clk) #1;
        reset = 0; instr_valid = 0;
        chk("full_rst_valid", {31'h0, out_valid}, 32'd0);
        chk("full_rst_ready", {31'h0, instr_ready}, 32'd1);
        chk("full_rst_fields", {6'h0, fields()}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("full_rst_stays_empty", {31'h0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Decode stage between instruction fetch and the immediate sign extender in the 16-bit CPU datapath. Accepts 16-bit instruction words over a valid/ready handshake and buffers them. Splits each word into opcode, register and immediate fields, and classifies the immediate as signed or unsigned. Drives `imm8` and `imm_signed` straight into the sign extender's `In`/`S` inputs, and the register fields to the register file.

## Interface
- `OPW`, 4: opcode field width (bits [15:12]); fixed by ISA, not for override.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `instr` input 16: fetched instruction word.
- `instr_valid` input 1: `instr` holds a valid word.
- `instr_ready` output 1: stage accepts a word this cycle.
- `out_ready` input 1: downstream consumes the current output this cycle.
- `out_valid` output 1: decoded outputs are valid.
- `opcode` output 4: `instr[15:12]`.
- `rdest` output 4: `instr[11:8]`.
- `ext` output 4: `instr[7:4]`, the op extension or high immediate nibble.
- `rsrc` output 4: `instr[3:0]`.
- `imm8` output 8: `instr[7:0]`, routed to the sign extender `In`.
- `imm_signed` output 1: routed to the sign extender `S`.
- `is_imm` output 1: the instruction uses `imm8` as an operand.

## Operation
- Transfer in occurs when `instr_valid && instr_ready`. Transfer out occurs when `out_valid && out_ready`.
- Buffer is 2 entries deep. Occupancy FSM has three states:
  - EMPTY: `instr_ready`=1, `out_valid`=0.
  - ONE: `instr_ready`=1, `out_valid`=1.
  - TWO: `instr_ready`=0, `out_valid`=1.
- FSM transitions:
  - EMPTY→ONE on transfer in.
  - ONE→TWO on transfer in without transfer out.
  - ONE→EMPTY on transfer out without transfer in.
  - ONE stays ONE on simultaneous transfer in and out; the head is replaced by the new word.
  - TWO→ONE on transfer out; the second entry moves to the head.
  - TWO never accepts input.
- Outputs always decode the head entry. When `out_valid`=0, all decoded outputs are 0.
- Field classification by `opcode`:
  - 0000 (register ALU), 0100 (load/store/jump), 1000 (shift): `is_imm`=0, `imm_signed`=0.
  - 0101 ADDI, 1001 SUBI, 1011 CMPI, 1100 Bcond displacement: `is_imm`=1, `imm_signed`=1.
  - 0001 ANDI, 0010 ORI, 0011 XORI, 1101 MOVI, 1111 LUI: `is_imm`=1, `imm_signed`=0.
  - All other opcodes (0110, 0111, 1010, 1110): `is_imm`=0, `imm_signed`=0. The word still passes through.
- Buffer order is strictly FIFO. No word is dropped or duplicated.

## Timing
- Reset values: FSM in EMPTY, both entries 0, `out_valid`=0, `instr_ready`=1, all field outputs 0.
- Reset mid-operation discards buffered words at the next edge. Any handshake in that same cycle is ignored.
- Latency: a word accepted at edge N appears on the outputs after edge N, i.e. visible in cycle N+1.
- Throughput is 1 word per cycle while `out_ready` is held at 1.
- `instr_ready` depends only on registered state, with no combinational path from `out_ready`; this holds when `IMM_DECODE_SKID_EN` is defined (see Configuration).
- Decode is combinational from the head register. Outputs are stable while `out_valid`=1 and `out_ready`=0.

## Configuration
- `IMM_DECODE_SKID_EN` defined: 2-entry buffer as described; `instr_ready` is registered.
- Not defined: single entry, and the FSM reduces to EMPTY/ONE.
  - `instr_ready` = `!out_valid || out_ready`, a combinational path from `out_ready`.
  - Latency and decode rules are unchanged.
  - Throughput is still 1 word per cycle.

## Structure
- Shared package `cpu_isa_pkg` holds:
  - opcode localparams `OP_RTYPE`, `OP_ANDI`, `OP_ORI`, `OP_XORI`, `OP_SPECIAL`, `OP_ADDI`, `OP_SHIFT`, `OP_SUBI`, `OP_CMPI`, `OP_BCOND`, `OP_MOVI`, `OP_LUI`;
  - the field bit positions.
- One sub-module, `imm_classify`: combinational map from opcode to {`is_imm`, `imm_signed`}. It is reused by the control unit.
- The buffer/FSM lives in the top module.

## Test plan
- Reset: assert `reset` with `instr_valid`=1 → after the edge, `out_valid`=0, `instr_ready`=1, `imm8`=0.
- ADDI: send 0x51FF with `out_ready`=1 → next cycle `opcode`=5, `rdest`=1, `imm8`=0xFF, `imm_signed`=1, `is_imm`=1. Sign extender output is 0xFFFF.
- ANDI: send 0x120F → `imm8`=0x0F, `imm_signed`=0. Sign extender output is 0x000F.
- Backpressure: hold `out_ready`=0, send 0x5301, 0x9402, 0xD503.
  - With `IMM_DECODE_SKID_EN`: `instr_ready` drops after the second word, and the third word waits.
  - Release `out_ready` → outputs appear in order 0x5301, 0x9402, 0xD503, then `out_valid`=0.
- Streaming: 100 random words with `instr_valid` and `out_ready` continuously 1 → one output per cycle, in order, with a 1-cycle latency.
- Simultaneous events: in ONE state, transfer in and out on the same edge → state stays ONE, the head becomes the new word, and no word is lost. Assert `reset` while in TWO → EMPTY next cycle.
